// File: rtl/divmul_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// funct codes, FSM states, internal op encoding and the funct decoder.
package divmul_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned DCNT_W   = 6;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MADD  = 6'h00;
    localparam logic [5:0] FUNCT_MADDU = 6'h01;
    localparam logic [5:0] FUNCT_MUL   = 6'h02;
    localparam logic [5:0] FUNCT_MSUB  = 6'h04;
    localparam logic [5:0] FUNCT_MSUBU = 6'h05;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MUL, ST_ACC, ST_DIV, ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
        MD_MUL, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
    } md_op_e;

    // Map opcode class + funct onto the internal op; MD_NONE for anything else.
    function automatic md_op_e decode_op(input logic special2, input logic [5:0] funct);
        md_op_e op;
        op = MD_NONE;
        if (special2) begin
            case (funct)
                FUNCT_MUL:   op = MD_MUL;
                FUNCT_MADD:  op = MD_MADD;
                FUNCT_MADDU: op = MD_MADDU;
                FUNCT_MSUB:  op = MD_MSUB;
                FUNCT_MSUBU: op = MD_MSUBU;
                default:     op = MD_NONE;
            endcase
        end else begin
            case (funct)
                FUNCT_MULT:  op = MD_MULT;
                FUNCT_MULTU: op = MD_MULTU;
                FUNCT_DIV:   op = MD_DIV;
                FUNCT_DIVU:  op = MD_DIVU;
                default:     op = MD_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative restoring divider, one quotient bit per cycle; start latches the
// operand magnitudes, done flags the final iteration with sign-corrected q/r.
module div_radix2
    import divmul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            sign_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] q_o,
    output logic [XLEN-1:0] r_o,
    output logic            done_o
);

    logic              busy_q;
    logic [DCNT_W-1:0] cnt_q;
    logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
    logic              neg_q_q, neg_r_q;

    logic              a_neg, b_neg, b_zero;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   rem_sub, rem_n, quo_n;

    assign a_neg  = sign_i & a_i[XLEN-1];
    assign b_neg  = sign_i & b_i[XLEN-1];
    assign b_zero = (b_i == '0);
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;

    // A zero divisor makes every step "fit", giving all-ones and rem = |a|.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign ge      = (shifted >= {1'b0, dvs_q});
    assign rem_sub = shifted[XLEN-1:0] - dvs_q;
    assign rem_n   = ge ? rem_sub : shifted[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], ge};

    assign done_o = busy_q & (cnt_q == DCNT_W'(1));
    assign q_o    = neg_q_q ? -quo_n : quo_n;
    assign r_o    = neg_r_q ? -rem_n : rem_n;

    always_ff @(posedge clk) begin
        if (rst || abort_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= DCNT_W'(DIV_ITER);
            quo_q   <= a_mag;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            neg_q_q <= (a_neg ^ b_neg) & ~b_zero;
            neg_r_q <= a_neg;
        end else if (busy_q) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - DCNT_W'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/divmul_ctrl.sv
// Execute-stage sequencer for the shared multiply/divide unit: stalls the pipe
// while a mul/div runs, does the HI/LO accumulate, and drives the HI/LO write.
module divmul_ctrl
    import divmul_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            special2_i,
    input  logic [5:0]      funct_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic            flush_i,
    input  logic            mem_stall_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            hilo_we_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            gpr_valid_o
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned PW    = 2 * XLEN;

    state_e            state_q;
    md_op_e            op_q;
    md_op_e            start_op;
    logic [XLEN-1:0]   a_q, b_q, hacc_q, lacc_q, hi_q, lo_q;
    logic [PW-1:0]     prod_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, start_div, op_signed, op_acc, op_sub;
    logic [PW-1:0]     ext_a, ext_b, product, acc_res;
    logic              div_start, div_done;
    logic [XLEN-1:0]   div_q, div_r;

    assign start_op  = decode_op(special2_i, funct_i);
    assign accept    = (state_q == ST_IDLE) & start_i & ~flush_i & (start_op != MD_NONE);
    assign start_div = (start_op == MD_DIV) | (start_op == MD_DIVU);

    assign op_signed = (op_q == MD_MULT) | (op_q == MD_MUL) | (op_q == MD_MADD) |
                       (op_q == MD_MSUB) | (op_q == MD_DIV);
    assign op_acc    = (op_q == MD_MADD) | (op_q == MD_MADDU) | op_sub;
    assign op_sub    = (op_q == MD_MSUB) | (op_q == MD_MSUBU);

    // Sign/zero-extend to 64 bits so one unsigned multiply serves both flavours.
    assign ext_a   = op_signed ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    assign ext_b   = op_signed ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    assign product = ext_a * ext_b;
    assign acc_res = op_sub ? ({hacc_q, lacc_q} - prod_q) : ({hacc_q, lacc_q} + prod_q);

    // The first DIV cycle (cnt_q != 0) is the divider's setup cycle.
    assign div_start = (state_q == ST_DIV) & (cnt_q != '0) & ~flush_i;

    div_radix2 u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .abort_i (flush_i),
        .sign_i  (op_signed),
        .a_i     (a_q),
        .b_i     (b_q),
        .q_o     (div_q),
        .r_o     (div_r),
        .done_o  (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hacc_q  <= '0;
            lacc_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= src_a_i;
                        b_q     <= src_b_i;
                        hacc_q  <= hi_i;
                        lacc_q  <= lo_i;
                        op_q    <= start_op;
                        cnt_q   <= start_div ? CNT_W'(1) : CNT_W'(MUL_LAT - 1);
                        state_q <= start_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod_q <= product;
                    if (cnt_q == '0) begin
                        if (op_acc) begin
                            state_q <= ST_ACC;
                        end else begin
                            {hi_q, lo_q} <= product;
                            state_q      <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ACC: begin
                    {hi_q, lo_q} <= acc_res;
                    state_q      <= ST_DONE;
                end
                ST_DIV: begin
                    cnt_q <= '0;
                    if (div_done) begin
                        hi_q    <= div_r;
                        lo_q    <= div_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!mem_stall_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall must drop in the same cycle as a flush, hence the direct gating.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE:                  stall_o = accept;
            ST_MUL, ST_ACC, ST_DIV:   stall_o = ~flush_i;
            default:                  stall_o = 1'b0;
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign hilo_we_o   = (state_q == ST_DONE) & ~mem_stall_i & ~flush_i & (op_q != MD_MUL);
    assign gpr_valid_o = (state_q == ST_DONE) & ~flush_i & (op_q == MD_MUL);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule

// File: doc/divmul_ctrl.md
Name: divmul_ctrl

Overview:
- Execute-stage sequencer for the shared multiply/divide resource; started by the decoder's DivMulEn flag (carried to E) together with the funct field and SPECIAL2 flag.
- Runs a multi-cycle multiply or a radix-2 iterative divide, stalls the pipeline until the result is ready, and performs the HI/LO accumulate step for MADD/MADDU/MSUB/MSUBU.
- Drives the HI/LO write port, and drives the GPR result for SPECIAL2 MUL.

Parameters:
- MUL_LAT, 2, cycles spent in the multiply state (pipelined multiplier depth); legal range 1..4.
- DIV_ITER, 32, number of restoring-division iterations; fixed to the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  DivMulEnE: a mul/div-class instruction is valid in E
- special2_i  in  1  1 = SPECIAL2 opcode (MUL/MADD*/MSUB*), 0 = R_TYPE (MULT/MULTU/DIV/DIVU)
- funct_i  in  6  instruction funct field
- src_a_i  in  32  rs value (forwarded)
- src_b_i  in  32  rt value (forwarded)
- hi_i  in  32  current HI (accumulate source)
- lo_i  in  32  current LO (accumulate source)
- flush_i  in  1  exception/eret flush of E
- mem_stall_i  in  1  downstream stall; the result must be held
- stall_o  out  1  hold F/D/E
- busy_o  out  1  state != IDLE
- hilo_we_o  out  1  one-cycle write of HI/LO
- hi_o  out  32  HI result
- lo_o  out  32  LO result; also the GPR result for MUL
- gpr_valid_o  out  1  MUL result valid for the E->M register

Behaviour:
- Reset: state IDLE; all outputs 0; operand, accumulator and counter registers cleared.
- States: IDLE, MUL, ACC, DIV, DONE.
- IDLE:
  - On start_i & ~flush_i, latch operands, hi_i/lo_i and the op.
  - Next state is DIV for DIV/DIVU, otherwise MUL.
  - stall_o = start_i & ~flush_i (combinational) in this cycle.
  - Unrecognised funct with start_i: stay IDLE, no stall.
- MUL:
  - 64-bit product; signed for MULT/MADD/MSUB/MUL, unsigned for MULTU/MADDU/MSUBU.
  - Stays MUL_LAT cycles (down-counter), then goes to ACC for MADD*/MSUB*, else DONE.
- ACC: {hi,lo} = {hi_l,lo_l} +/- product, modulo 2^64, one cycle, then DONE.
- DIV:
  - Setup cycle takes magnitudes for DIV.
  - Then DIV_ITER iterations, one quotient bit per cycle.
  - Final cycle applies sign fix-up: quotient negative iff signs differ; remainder takes the dividend's sign. Then DONE.
  - Divide by zero: same latency; quotient 0xFFFFFFFF, remainder = dividend.
- Start-to-DONE latency: MULT/MULTU/MUL = MUL_LAT+1 cycles; MADD*/MSUB* = MUL_LAT+2; DIV/DIVU = 34.
- stall_o = 1 in MUL, ACC and DIV; 0 in DONE.
- DONE:
  - hi_o/lo_o valid.
  - hilo_we_o = ~mem_stall_i & ~MUL.
  - gpr_valid_o = MUL op.
  - While mem_stall_i is high: remain in DONE, outputs held, no write.
  - Otherwise go to IDLE next cycle. Exactly one hilo_we_o pulse per instruction.
- flush_i in any state: next state IDLE, no hilo_we_o this cycle or later, and stall_o drops the same cycle. flush_i has priority over start_i.
- rst mid-operation: abort as for flush; all registers return to reset values.
- A new start_i is accepted only in IDLE; start_i is ignored in DONE. The pipeline advances out of DONE, so the next instruction arrives in the following cycle.
- MFHI/MFLO are not handled here; the hazard unit sees busy_o.

Decomposition:
- Shared package (defines2-style): funct codes MULT, MULTU, DIV, DIVU, MUL, MADD, MADDU, MSUB, MSUBU; a state enum; an internal 4-bit op encoding MD_MULT..MD_MSUBU.
- One sub-module: div_radix2, the iterative divider datapath.
  - Inputs: start, sign, a, b.
  - Outputs: q, r, done.
  - The controller owns its start/abort.
- The multiplier stays an inline registered product in divmul_ctrl.

Test Plan:
- MULT 0xFFFFFFFE x 3 -> after 3 cycles (MUL_LAT=2), hilo_we_o with hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_o high for exactly 3 cycles.
- DIV -7 / 2 -> done at cycle 34, lo (quotient) = 0xFFFFFFFD, hi (remainder) = 0xFFFFFFFF. Repeat as DIVU 7/2 -> lo=3, hi=1.
- MADDU with hi=0, lo=0xFFFFFFFF, operands 1 x 1 -> hi=1, lo=0 at cycle 4. MSUB with zero accumulators, operands 1 x 1 -> hi=lo=0xFFFFFFFF.
- flush_i at iteration 10 of a DIV -> IDLE next cycle, stall_o low the same cycle, no hilo_we_o. An immediate new MULT then completes normally.
- DONE with mem_stall_i high for 5 cycles -> outputs stable, hilo_we_o=0; exactly one pulse when it drops. MUL 6 x 7 -> gpr_valid_o with lo=42, hilo_we_o never asserted.
- DIVU 5 / 0 -> latency 34, lo=0xFFFFFFFF, hi=5. rst asserted at cycle 20 of the divide -> all outputs 0 the next cycle.
